// File: rtl/pcm_frame_sched_if.sv
// rtl/pcm_frame_sched_if.sv - PCM input, packet BRAM write, and Ethernet handoff signals of the frame scheduler
interface pcm_frame_sched_if #(
    parameter int ADDR_W = 10
) ();
    logic              pcm_stb;
    logic [15:0]       pcm_l;
    logic [15:0]       pcm_r;
    logic              bram_wr_en;
    logic [ADDR_W-1:0] bram_wr_addr;
    logic [7:0]        bram_wr_data;
    logic              eth_start;
    logic              eth_busy;
    logic              eth_bank;
    logic [7:0]        frame_seq;
    logic [7:0]        drop_cnt;
    logic              overrun;
    logic              tx_timeout;

    // Sample source / transmitter side
    modport master (
        output pcm_stb, pcm_l, pcm_r, eth_busy,
        input  bram_wr_en, bram_wr_addr, bram_wr_data, eth_start, eth_bank,
               frame_seq, drop_cnt, overrun, tx_timeout
    );

    // Scheduler side
    modport slave (
        input  pcm_stb, pcm_l, pcm_r, eth_busy,
        output bram_wr_en, bram_wr_addr, bram_wr_data, eth_start, eth_bank,
               frame_seq, drop_cnt, overrun, tx_timeout
    );
endinterface

// File: rtl/pcm_frame_sched.sv
// rtl/pcm_frame_sched.sv - ping-pong stereo PCM frame scheduler feeding the Ethernet transmitter
module pcm_frame_sched #(
    parameter int HDR_LEN = 14,
    parameter int PAIRS   = 28,
    parameter int ADDR_W  = 10,
    parameter int BUSY_TO = 15
) (
    input  logic            clk,
    input  logic            rst,
    pcm_frame_sched_if.slave bus
);
    localparam int OFF_W = ADDR_W - 1;
    localparam int PC_W  = $clog2(PAIRS + 1);
    localparam int TO_W  = $clog2(BUSY_TO + 1);
    localparam logic [OFF_W-1:0] HDR_OFF = OFF_W'(HDR_LEN);

    if (HDR_LEN + 4 * PAIRS > (1 << (ADDR_W - 1))) begin : g_len_check
        $error("pcm_frame_sched: header plus payload does not fit in one bank");
    end

    typedef enum logic [2:0] {W_IDLE, W0, W1, W2, W3, W_NEXT} w_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;

    w_state_t          w_q, w_d;
    tx_state_t         tx_q, tx_d;
    logic              wr_bank_q, wr_bank_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [PC_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic              pending_q, pending_d;
    logic              eth_bank_q, eth_bank_d;
    logic [7:0]        frame_seq_q, frame_seq_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]       l_q, l_d, r_q, r_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [7:0]        wr_data_c;
    logic              overrun_c;
    logic              pending_set, pending_clr;
    logic              start_c, timeout_c;
    logic              tx_free;

    // The writer may only hand off when nothing is queued and the transmitter is, or is just becoming, idle.
    assign tx_free = !pending_q &&
                     (tx_q == TX_IDLE || (tx_q == TX_WAIT_DONE && !bus.eth_busy));

    always_comb begin
        w_d         = w_q;
        wr_bank_d   = wr_bank_q;
        offset_d    = offset_q;
        pair_cnt_d  = pair_cnt_q;
        eth_bank_d  = eth_bank_q;
        drop_cnt_d  = drop_cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        wr_en_c     = 1'b0;
        wr_addr_c   = '0;
        wr_data_c   = '0;
        pending_set = 1'b0;
        overrun_c   = bus.pcm_stb && (w_q != W_IDLE);
        case (w_q)
            W_IDLE: begin
                if (bus.pcm_stb) begin
                    l_d = bus.pcm_l;
                    r_d = bus.pcm_r;
                    w_d = W0;
                end
            end
            W0: begin
                wr_en_c   = 1'b1;
                wr_addr_c = {wr_bank_q, offset_q};
                wr_data_c = l_q[7:0];
                w_d       = W1;
            end
            W1: begin
                wr_en_c   = 1'b1;
                wr_addr_c = {wr_bank_q, offset_q + OFF_W'(1)};
                wr_data_c = l_q[15:8];
                w_d       = W2;
            end
            W2: begin
                wr_en_c   = 1'b1;
                wr_addr_c = {wr_bank_q, offset_q + OFF_W'(2)};
                wr_data_c = r_q[7:0];
                w_d       = W3;
            end
            W3: begin
                wr_en_c   = 1'b1;
                wr_addr_c = {wr_bank_q, offset_q + OFF_W'(3)};
                wr_data_c = r_q[15:8];
                w_d       = W_NEXT;
            end
            W_NEXT: begin
                w_d = W_IDLE;
                if (pair_cnt_q == PC_W'(PAIRS - 1)) begin
                    offset_d   = HDR_OFF;
                    pair_cnt_d = '0;
                    if (tx_free) begin
                        pending_set = 1'b1;
                        eth_bank_d  = wr_bank_q;
                        wr_bank_d   = ~wr_bank_q;
                    end else begin
                        // Whole frame discarded; the same bank is refilled from the header.
                        overrun_c = 1'b1;
                        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end else begin
                    offset_d   = offset_q + OFF_W'(4);
                    pair_cnt_d = pair_cnt_q + PC_W'(1);
                end
            end
            default: w_d = W_IDLE;
        endcase
    end

    always_comb begin
        tx_d        = tx_q;
        to_cnt_d    = to_cnt_q;
        frame_seq_d = frame_seq_q;
        start_c     = 1'b0;
        timeout_c   = 1'b0;
        pending_clr = 1'b0;
        case (tx_q)
            TX_IDLE: begin
                if (pending_q) tx_d = TX_START;
            end
            TX_START: begin
                start_c     = 1'b1;
                pending_clr = 1'b1;
                frame_seq_d = frame_seq_q + 8'd1;
                to_cnt_d    = '0;
                tx_d        = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (bus.eth_busy) begin
                    tx_d = TX_WAIT_DONE;
                end else if (to_cnt_q == TO_W'(BUSY_TO - 1)) begin
                    timeout_c = 1'b1;
                    tx_d      = TX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            TX_WAIT_DONE: begin
                if (!bus.eth_busy) tx_d = TX_IDLE;
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    assign pending_d = pending_set ? 1'b1 : (pending_clr ? 1'b0 : pending_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q         <= W_IDLE;
            tx_q        <= TX_IDLE;
            wr_bank_q   <= 1'b0;
            offset_q    <= HDR_OFF;
            pair_cnt_q  <= '0;
            pending_q   <= 1'b0;
            eth_bank_q  <= 1'b0;
            frame_seq_q <= '0;
            drop_cnt_q  <= '0;
            l_q         <= '0;
            r_q         <= '0;
            to_cnt_q    <= '0;
        end else begin
            w_q         <= w_d;
            tx_q        <= tx_d;
            wr_bank_q   <= wr_bank_d;
            offset_q    <= offset_d;
            pair_cnt_q  <= pair_cnt_d;
            pending_q   <= pending_d;
            eth_bank_q  <= eth_bank_d;
            frame_seq_q <= frame_seq_d;
            drop_cnt_q  <= drop_cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.bram_wr_en   = wr_en_c;
    assign bus.bram_wr_addr = wr_addr_c;
    assign bus.bram_wr_data = wr_data_c;
    assign bus.eth_start    = start_c;
    assign bus.eth_bank     = eth_bank_q;
    assign bus.frame_seq    = frame_seq_q;
    assign bus.drop_cnt     = drop_cnt_q;
    assign bus.overrun      = overrun_c;
    assign bus.tx_timeout   = timeout_c;
endmodule

// File: tb/tb_pcm_frame_sched.sv
// tb/tb_pcm_frame_sched.sv - directed self-checking bench for pcm_frame_sched
module tb_pcm_frame_sched;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_cnt = 0, start_cnt = 0, ovr_cnt = 0, to_cnt = 0;
    int start_cyc = 0, to_cyc = 0, stb_cyc = 0;
    int busy_len = 0, busy_cnt = 0;
    int s_wr = 0, s_start = 0, s_ovr = 0, s_to = 0;
    int mark = 0, wc = 0;
    logic [7:0]        mem     [0:1023];
    logic [ADDR_W-1:0] wr_log  [0:4095];
    logic              start_log [0:63];

    pcm_frame_sched_if #(.ADDR_W(ADDR_W)) bif ();

    pcm_frame_sched #(
        .HDR_LEN(14), .PAIRS(28), .ADDR_W(ADDR_W), .BUSY_TO(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and transmitter model, sampled on the falling edge
    initial begin
        bif.eth_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.bram_wr_en) begin
                mem[bif.bram_wr_addr] = bif.bram_wr_data;
                wr_log[wr_cnt[11:0]] = bif.bram_wr_addr;
                wr_cnt++;
            end
            if (bif.eth_start) begin
                start_log[start_cnt[5:0]] = bif.eth_bank;
                start_cyc = cyc;
                start_cnt++;
            end
            if (bif.overrun) ovr_cnt++;
            if (bif.tx_timeout) begin
                to_cyc = cyc;
                to_cnt++;
            end
            if (rst) busy_cnt = 0;
            else if (bif.eth_start && busy_len > 0) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            bif.eth_busy = (busy_cnt > 0);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bif.bram_wr_en, bif.bram_wr_addr, bif.bram_wr_data, bif.eth_start,
                    bif.eth_bank, bif.frame_seq, bif.drop_cnt, bif.overrun, bif.tx_timeout});
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk);
        #1;
        bif.pcm_stb = 1'b1;
        bif.pcm_l   = l;
        bif.pcm_r   = r;
        stb_cyc     = cyc;
        @(posedge clk);
        #1;
        bif.pcm_stb = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        strobe(l, r);
        tick(18);
    endtask

    task automatic send_frame(input logic [15:0] l0, input logic [15:0] r0);
        for (int n = 0; n < 28; n++) send_pair(l0 + 16'(n), r0 - 16'(n));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        s_wr    = wr_cnt;
        s_start = start_cnt;
        s_ovr   = ovr_cnt;
        s_to    = to_cnt;
    endtask

    initial begin
        bif.pcm_stb = 1'b0;
        bif.pcm_l   = '0;
        bif.pcm_r   = '0;

        // Single frame into bank 0, handoff latency and bank switch
        busy_len = 300;
        do_reset();
        @(negedge clk);
        check_eq("reset_outputs", outs(), 64'h0);
        mark = wr_cnt;
        send_frame(16'h1234, 16'hABCD);
        tick(10);
        check_eq("f1_first_addr", 64'(wr_log[mark[11:0]]), 64'd14);
        check_eq("f1_byte14", 64'(mem[14]), 64'h34);
        check_eq("f1_byte15", 64'(mem[15]), 64'h12);
        check_eq("f1_byte16", 64'(mem[16]), 64'hCD);
        check_eq("f1_byte17", 64'(mem[17]), 64'hAB);
        check_eq("f1_byte122", 64'(mem[122]), 64'h4F);
        check_eq("f1_byte124", 64'(mem[124]), 64'hB2);
        check_eq("f1_byte125", 64'(mem[125]), 64'hAB);
        check_eq("f1_writes", 64'(wr_cnt - s_wr), 64'd112);
        check_eq("f1_starts", 64'(start_cnt - s_start), 64'd1);
        check_eq("f1_eth_bank", 64'(start_log[s_start[5:0]]), 64'd0);
        check_eq("f1_frame_seq", 64'(bif.frame_seq), 64'd1);
        check_eq("f1_start_latency", 64'(start_cyc - stb_cyc), 64'd7);

        // Three more frames with a well-behaved transmitter
        mark = wr_cnt;
        send_frame(16'h1000, 16'h2000);
        check_eq("f2_first_addr", 64'(wr_log[mark[11:0]]), 64'd526);
        send_frame(16'h3000, 16'h4000);
        send_frame(16'h5000, 16'h6000);
        tick(320);
        check_eq("pp_starts", 64'(start_cnt - s_start), 64'd4);
        check_eq("pp_bank1", 64'(start_log[6'(s_start + 1)]), 64'd1);
        check_eq("pp_bank2", 64'(start_log[6'(s_start + 2)]), 64'd0);
        check_eq("pp_bank3", 64'(start_log[6'(s_start + 3)]), 64'd1);
        check_eq("pp_frame_seq", 64'(bif.frame_seq), 64'd4);
        check_eq("pp_drop_cnt", 64'(bif.drop_cnt), 64'd0);
        check_eq("pp_overrun", 64'(ovr_cnt - s_ovr), 64'd0);
        check_eq("pp_timeout", 64'(to_cnt - s_to), 64'd0);

        // Long busy: the frame completing during the transfer is dropped
        busy_len = 800;
        do_reset();
        send_frame(16'h0100, 16'h0200);
        send_frame(16'h0300, 16'h0400);
        tick(10);
        check_eq("drop_overrun", 64'(ovr_cnt - s_ovr), 64'd1);
        check_eq("drop_cnt", 64'(bif.drop_cnt), 64'd1);
        check_eq("drop_starts", 64'(start_cnt - s_start), 64'd1);
        mark = wr_cnt;
        send_frame(16'h0500, 16'h0600);
        tick(10);
        check_eq("drop_same_bank", 64'(wr_log[mark[11:0]]), 64'd526);
        check_eq("drop_next_start", 64'(start_cnt - s_start), 64'd2);
        check_eq("drop_next_bank", 64'(start_log[6'(s_start + 1)]), 64'd1);
        check_eq("drop_frame_seq", 64'(bif.frame_seq), 64'd2);
        check_eq("drop_cnt_hold", 64'(bif.drop_cnt), 64'd1);

        // Strobe while the writer is busy
        busy_len = 300;
        do_reset();
        @(posedge clk); #1;
        bif.pcm_stb = 1'b1; bif.pcm_l = 16'h1111; bif.pcm_r = 16'h2222;
        @(posedge clk); #1;
        bif.pcm_stb = 1'b0;
        @(posedge clk); #1;
        bif.pcm_stb = 1'b1; bif.pcm_l = 16'h3333; bif.pcm_r = 16'h4444;
        @(posedge clk); #1;
        bif.pcm_stb = 1'b0;
        tick(20);
        check_eq("miss_overrun", 64'(ovr_cnt - s_ovr), 64'd1);
        check_eq("miss_writes", 64'(wr_cnt - s_wr), 64'd4);
        check_eq("miss_byte14", 64'(mem[14]), 64'h11);
        check_eq("miss_byte16", 64'(mem[16]), 64'h22);
        check_eq("miss_drop_cnt", 64'(bif.drop_cnt), 64'd0);
        mark = wr_cnt;
        send_pair(16'h5555, 16'h6666);
        check_eq("miss_next_addr", 64'(wr_log[mark[11:0]]), 64'd18);

        // Transmitter never acknowledges
        busy_len = 0;
        do_reset();
        send_frame(16'h0A00, 16'h0B00);
        tick(30);
        check_eq("to_starts", 64'(start_cnt - s_start), 64'd1);
        check_eq("to_pulses", 64'(to_cnt - s_to), 64'd1);
        check_eq("to_latency", 64'(to_cyc - start_cyc), 64'd15);
        busy_len = 300;
        mark = wr_cnt;
        send_frame(16'h0C00, 16'h0D00);
        tick(10);
        check_eq("to_next_addr", 64'(wr_log[mark[11:0]]), 64'd526);
        check_eq("to_next_start", 64'(start_cnt - s_start), 64'd2);
        check_eq("to_next_bank", 64'(start_log[6'(s_start + 1)]), 64'd1);
        check_eq("to_frame_seq", 64'(bif.frame_seq), 64'd2);
        check_eq("to_pulses_after", 64'(to_cnt - s_to), 64'd1);

        // Reset in the middle of the last pair of a frame
        do_reset();
        send_frame(16'h0E00, 16'h0F00);
        for (int n = 0; n < 27; n++) send_pair(16'h7000 + 16'(n), 16'h8000 + 16'(n));
        @(posedge clk); #1;
        bif.pcm_stb = 1'b1; bif.pcm_l = 16'h7FFF; bif.pcm_r = 16'h8FFF;
        @(posedge clk); #1;
        bif.pcm_stb = 1'b0;
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_in_w2", 64'(bif.bram_wr_en), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_outputs", outs(), 64'h0);
        wc = wr_cnt;
        tick(20);
        check_eq("rst_no_writes", 64'(wr_cnt - wc), 64'd0);
        mark = wr_cnt;
        send_pair(16'h9999, 16'hAAAA);
        tick(20);
        check_eq("rst_first_addr", 64'(wr_log[mark[11:0]]), 64'd14);
        check_eq("rst_no_start", 64'(start_cnt - s_start), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
